// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: owns NUM_SLOTS falling obstacles and runs one
// MOVE/SPAWN pass per video frame. It moves live slots down, retires
// slots that leave the screen, spawns new ones and frees slots on hit.
module obstacle_scheduler #(
    parameter int NUM_SLOTS       = 4,
    parameter int SCREEN_WIDTH    = 640,
    parameter int SCREEN_HEIGHT   = 480,
    parameter int OBJECT_WIDTH_X  = 100,
    parameter int OBJECT_HEIGHT_Y = 100,
    parameter int SPAWN_PERIOD    = 60,
    parameter int SPEED_INIT      = 1,
    parameter int SPEED_MAX       = 8,
    parameter int LEVEL_SPAWNS    = 10
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    startOfFrame,
    input  logic                    enable,
    input  logic [10:0]             randX,
    input  logic [NUM_SLOTS-1:0]    hitMask,
    output logic [NUM_SLOTS*11-1:0] topLeftX,
    output logic [NUM_SLOTS*11-1:0] topLeftY,
    output logic [NUM_SLOTS-1:0]    activeMask,
    output logic                    escapedPulse,
    output logic [3:0]              speed,
    output logic                    busy
);
    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int FC_W  = $clog2(SPAWN_PERIOD + 1);
    localparam int SC_W  = $clog2(LEVEL_SPAWNS + 1);

    // Largest legal top-left X so the whole obstacle stays on screen.
    localparam logic [10:0]        X_LIMIT = 11'(SCREEN_WIDTH - OBJECT_WIDTH_X);
    localparam logic signed [10:0] Y_LIMIT = 11'(SCREEN_HEIGHT);
    // New obstacles start fully above the visible area.
    localparam logic signed [10:0] Y_SPAWN = 11'(-OBJECT_HEIGHT_Y);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MOVE  = 2'd1;
    localparam logic [1:0] SPAWN = 2'd2;

    logic [1:0]              state;
    logic [IDX_W-1:0]        idx;
    logic [FC_W-1:0]         frameCnt;
    logic [SC_W-1:0]         spawnCnt;
    logic [NUM_SLOTS-1:0]    active;
    logic [NUM_SLOTS-1:0]    activeNext;
    logic signed [10:0]      posX [NUM_SLOTS];
    logic signed [10:0]      posY [NUM_SLOTS];
    logic signed [10:0]      movedY;
    logic                    moveEsc;
    logic                    escNext;
    logic                    anyFree;
    logic [IDX_W-1:0]        freeIdx;
    logic [10:0]             wrapX;
    logic [10:0]             spawnX;
    logic                    doSpawn;

    // Candidate Y for the slot under MOVE and whether it falls off the bottom.
    assign movedY  = posY[idx] + $signed({7'd0, speed});
    assign moveEsc = (movedY >= Y_LIMIT);

    // Lowest-index free slot is the spawn target.
    always_comb begin
        anyFree = 1'b0;
        freeIdx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!active[i]) begin
                anyFree = 1'b1;
                freeIdx = IDX_W'(i);
            end
        end
    end

    // Fold an out-of-range random X back once; give up to 0 if still too wide.
    always_comb begin
        wrapX = randX - X_LIMIT;
        if (randX <= X_LIMIT)
            spawnX = randX;
        else if (wrapX <= X_LIMIT)
            spawnX = wrapX;
        else
            spawnX = '0;
    end

    assign doSpawn = (state == SPAWN) && (frameCnt == FC_W'(SPAWN_PERIOD)) && anyFree;

    // Active-mask update: escape, then hits, then spawn (spawn target was free anyway).
    always_comb begin
        activeNext = active;
        escNext    = 1'b0;
        if (state == MOVE && active[idx] && moveEsc) begin
            activeNext[idx] = 1'b0;
            escNext         = !hitMask[idx];
        end
        activeNext = activeNext & ~hitMask;
        if (doSpawn)
            activeNext[freeIdx] = 1'b1;
    end

    // Pass sequencer plus per-slot position, frame/spawn counters and speed.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            idx          <= '0;
            frameCnt     <= '0;
            spawnCnt     <= '0;
            speed        <= 4'(SPEED_INIT);
            active       <= '0;
            escapedPulse <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                posX[i] <= '0;
                posY[i] <= Y_SPAWN;
            end
        end else begin
            active       <= activeNext;
            escapedPulse <= escNext;
            case (state)
                IDLE: begin
                    if (startOfFrame && enable) begin
                        state <= MOVE;
                        idx   <= '0;
                        if (frameCnt != FC_W'(SPAWN_PERIOD))
                            frameCnt <= frameCnt + 1'b1;
                    end
                end
                MOVE: begin
                    if (active[idx])
                        posY[idx] <= movedY;
                    if (idx == IDX_W'(NUM_SLOTS - 1))
                        state <= SPAWN;
                    else
                        idx <= idx + 1'b1;
                end
                SPAWN: begin
                    if (doSpawn) begin
                        posX[freeIdx] <= spawnX;
                        posY[freeIdx] <= Y_SPAWN;
                        frameCnt      <= '0;
                        if (spawnCnt == SC_W'(LEVEL_SPAWNS - 1)) begin
                            spawnCnt <= '0;
                            if (speed < 4'(SPEED_MAX))
                                speed <= speed + 1'b1;
                        end else begin
                            spawnCnt <= spawnCnt + 1'b1;
                        end
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Flatten slot positions onto the packed drawer buses.
    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
        assign topLeftX[11*g +: 11] = posX[g];
        assign topLeftY[11*g +: 11] = posY[g];
    end

    assign activeMask = active;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler: spawn timing, X folding,
// escape/hit priority, full-slot retry, speed levels, enable and reset.
module tb_obstacle_scheduler;
    localparam int NS = 4;

    logic            clk = 1'b0;
    logic            resetN;
    logic            startOfFrame;
    logic            enable;
    logic [10:0]     randX;
    logic [NS-1:0]   hitMask;
    logic [NS*11-1:0] topLeftX;
    logic [NS*11-1:0] topLeftY;
    logic [NS-1:0]   activeMask;
    logic            escapedPulse;
    logic [3:0]      speed;
    logic            busy;

    int              nChecks = 0;
    int              nFail   = 0;
    int              escCnt  = 0;
    logic [NS-1:0]   hitBase = '0;
    logic [10:0]     yInit   = 11'h79C;   // -100
    logic [NS*11-1:0] yReset;

    obstacle_scheduler dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .enable       (enable),
        .randX        (randX),
        .hitMask      (hitMask),
        .topLeftX     (topLeftX),
        .topLeftY     (topLeftY),
        .activeMask   (activeMask),
        .escapedPulse (escapedPulse),
        .speed        (speed),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] getX(input int i);
        return topLeftX[11*i +: 11];
    endfunction

    function automatic logic [10:0] getY(input int i);
        return topLeftY[11*i +: 11];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        hitMask      = hitBase;
        repeat (2) tick();
        resetN = 1'b1;
        tick();
    endtask

    // One frame: start pulse, MOVE+SPAWN cycles, one idle cycle; counts escapes.
    // hitCyc selects the cycle (0 = slot0 MOVE) in which hitMask is forced to hv.
    task automatic frame(input int hitCyc, input logic [NS-1:0] hv);
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        for (int c = 0; c < NS + 1; c++) begin
            hitMask = (c == hitCyc) ? hv : hitBase;
            tick();
            if (escapedPulse) escCnt++;
        end
        hitMask = hitBase;
        tick();
        if (escapedPulse) escCnt++;
    endtask

    task automatic run_frames(input int n);
        for (int f = 0; f < n; f++) frame(-1, '0);
    endtask

    task automatic x_case(input logic [10:0] rx, input logic [10:0] ex, input string tag);
        randX = rx;
        do_reset();
        run_frames(60);
        check(tag, getX(0), ex);
    endtask

    initial begin
        yReset = {yInit, yInit, yInit, yInit};
        enable = 1'b1;
        randX  = 11'd200;
        do_reset();

        // Reset state
        check("rst_active", activeMask, 4'b0000);
        check("rst_x", topLeftX, 44'd0);
        check("rst_y", topLeftY, yReset);
        check("rst_esc", escapedPulse, 1'b0);
        check("rst_speed", speed, 4'd1);
        check("rst_busy", busy, 1'b0);

        // First spawn lands exactly on frame 60
        run_frames(59);
        check("f59_active", activeMask, 4'b0000);
        frame(-1, '0);
        check("f60_active", activeMask, 4'b0001);
        check("f60_x0", getX(0), 11'd200);
        check("f60_y0", getY(0), 11'h79C);
        frame(-1, '0);
        check("f61_y0", getY(0), 11'h79D);

        // Pass latency and a second start pulse while busy
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        check("busy_move", busy, 1'b1);
        tick();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        repeat (2) tick();
        check("busy_spawn", busy, 1'b1);
        tick();
        check("busy_done", busy, 1'b0);
        tick();
        check("busy_ignored", busy, 1'b0);
        check("dbl_y0", getY(0), 11'h79E);

        // enable low freezes everything
        enable = 1'b0;
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        check("dis_busy", busy, 1'b0);
        run_frames(5);
        check("dis_y0", getY(0), 11'h79E);
        check("dis_active", activeMask, 4'b0001);
        enable = 1'b1;

        // X folding
        x_case(11'd700,  11'd160, "x700");
        x_case(11'd2000, 11'd0,   "x2000");
        x_case(11'd540,  11'd540, "x540");
        x_case(11'd541,  11'd1,   "x541");
        x_case(11'd1081, 11'd0,   "x1081");

        // Fill all slots (spawns at 60/120/180/240), then retry behaviour
        randX = 11'd200;
        do_reset();
        run_frames(400);
        check("full_active", activeMask, 4'b1111);
        check("full_y2", getY(2), 11'd120);
        hitMask = 4'b0100;
        tick();
        hitMask = hitBase;
        check("hit2_active", activeMask, 4'b1011);
        frame(-1, '0);
        check("respawn2_active", activeMask, 4'b1111);
        check("respawn2_y2", getY(2), 11'h79C);

        // Slot0 reaches 479 after frame 639, escapes on frame 640
        run_frames(238);
        check("pre_esc_y0", getY(0), 11'd479);
        check("pre_esc_speed", speed, 4'd1);
        escCnt = 0;
        frame(-1, '0);
        check("esc_count", escCnt, 1);
        check("esc_respawn_y0", getY(0), 11'h79C);
        check("esc_active", activeMask, 4'b1111);

        // Slot1 escapes on frame 700 but is hit in its MOVE cycle
        run_frames(59);
        check("pre_hit_y1", getY(1), 11'd479);
        escCnt = 0;
        frame(1, 4'b0010);
        check("hit_esc_count", escCnt, 0);
        check("hit_respawn_y1", getY(1), 11'h79C);

        // Reset mid-MOVE
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        tick();
        resetN = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_active", activeMask, 4'b0000);
        check("mid_rst_x", topLeftX, 44'd0);
        check("mid_rst_y", topLeftY, yReset);
        check("mid_rst_speed", speed, 4'd1);
        check("mid_rst_esc", escapedPulse, 1'b0);
        tick();
        resetN = 1'b1;

        // Speed levels: keep slots hit so every 60th frame spawns
        hitBase = 4'b1111;
        do_reset();
        run_frames(599);
        check("speed_599", speed, 4'd1);
        frame(-1, '0);
        check("speed_600", speed, 4'd2);
        run_frames(3600);
        check("speed_4200", speed, 4'd8);
        run_frames(600);
        check("speed_4800", speed, 4'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
